i2c_bus_arbiter: RTL and testbench

- Shares the single I2C byte master between NUM_REQ sensor/config controllers (altimeter controller, accelerometer controller, config loader).
- Grants the master to one requester for a whole multi-byte transaction, which lasts from START, through repeated starts, to STOP.
- Uses round-robin fairness.
- A watchdog revokes a hung owner.
- Sits between the controllers and the I2C master, on the master's ena/addr/rw/data_wr/busy/data_rd/ack_err interface.

---
 rtl/i2c_bus_arbiter.sv | 146 ++++++++++++++
 tb/tb_i2c_bus_arbiter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/i2c_bus_arbiter.sv
// Round-robin owner arbiter in front of a shared I2C byte master.
// One requester owns the master from START to STOP; a watchdog evicts a hung owner.
module i2c_bus_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  output logic [NUM_REQ-1:0]     gnt,
  input  logic [NUM_REQ-1:0]     req_ena,
  input  logic [7*NUM_REQ-1:0]   req_addr,
  input  logic [NUM_REQ-1:0]     req_rw,
  input  logic [8*NUM_REQ-1:0]   req_data_wr,
  output logic [NUM_REQ-1:0]     req_busy,
  output logic [NUM_REQ-1:0]     req_ack_err,
  output logic [7:0]             req_data_rd,
  output logic [NUM_REQ-1:0]     req_timeout,
  output logic                   m_ena,
  output logic [6:0]             m_addr,
  output logic                   m_rw,
  output logic [7:0]             m_data_wr,
  input  logic                   m_busy,
  input  logic                   m_ack_err,
  input  logic [7:0]             m_data_rd,
  output logic [1:0]             owner_id,
  output logic                   bus_active
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_FORCE} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [1:0]         owner_q, owner_d;
  logic [1:0]         last_q, last_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NUM_REQ-1:0] lock_q, lock_d;
  logic [NUM_REQ-1:0] tmo_q, tmo_d;

  logic [NUM_REQ-1:0] eligible;
  logic               found;
  int                 idx;
  int                 own;

  assign own = int'(owner_q);

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    owner_d  = owner_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    tmo_d    = '0;
    // A locked-out requester is forgiven as soon as it drops req.
    lock_d   = lock_q & req;
    eligible = req & ~lock_q;
    found    = 1'b0;
    idx      = 0;
    case (state_q)
      S_IDLE: begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          if (!found && eligible[(int'(last_q) + k) % NUM_REQ]) begin
            found = 1'b1;
            idx   = (int'(last_q) + k) % NUM_REQ;
          end
        end
        if (found) begin
          owner_d = 2'(idx);
          gnt_d   = ONE << idx;
          cnt_d   = '0;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        if (!req[own] && !m_busy) begin
          gnt_d   = '0;
          last_d  = owner_q;
          state_d = S_IDLE;
        end else if (cnt_q == CNT_MAX) begin
          gnt_d   = '0;
          tmo_d   = ONE << own;
          lock_d  = (lock_q | (ONE << own)) & req;
          state_d = S_FORCE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FORCE: begin
        if (!m_busy) begin
          last_d  = owner_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      last_q  <= 2'(NUM_REQ - 1);
      cnt_q   <= '0;
      lock_q  <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      lock_q  <= lock_d;
      tmo_q   <= tmo_d;
    end
  end

  // Master-side muxes decode straight from state_q so reset kills m_ena without a clock.
  always_comb begin
    m_ena       = 1'b0;
    m_addr      = '0;
    m_rw        = 1'b0;
    m_data_wr   = '0;
    req_busy    = '1;
    req_ack_err = '0;
    if (state_q == S_GRANT) begin
      m_ena            = req_ena[own];
      m_addr           = req_addr[7*own +: 7];
      m_rw             = req_rw[own];
      m_data_wr        = req_data_wr[8*own +: 8];
      req_busy[own]    = m_busy;
      req_ack_err[own] = m_ack_err;
    end
  end

  assign gnt         = gnt_q;
  assign req_timeout = tmo_q;
  assign owner_id    = owner_q;
  assign bus_active  = (state_q != S_IDLE);
  assign req_data_rd = m_data_rd;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed vector bench for i2c_bus_arbiter with a short watchdog.
module tb_i2c_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req = '0, req_ena = '0, req_rw = 3'b010;
  logic [20:0] req_addr = {7'h62, 7'h61, 7'h60};
  logic [23:0] req_data_wr = {8'hC2, 8'hC1, 8'hC0};
  logic [2:0]  gnt, req_busy, req_ack_err, req_timeout;
  logic [7:0]  req_data_rd, m_data_wr;
  logic        m_ena, m_rw, bus_active;
  logic [6:0]  m_addr;
  logic        m_busy = 1'b0, m_ack_err = 1'b0;
  logic [7:0]  m_data_rd = 8'hA5;
  logic [1:0]  owner_id;

  int nvec = 0;
  int nerr = 0;

  i2c_bus_arbiter #(.NUM_REQ(3), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .req_ena(req_ena),
    .req_addr(req_addr), .req_rw(req_rw), .req_data_wr(req_data_wr),
    .req_busy(req_busy), .req_ack_err(req_ack_err), .req_data_rd(req_data_rd),
    .req_timeout(req_timeout), .m_ena(m_ena), .m_addr(m_addr), .m_rw(m_rw),
    .m_data_wr(m_data_wr), .m_busy(m_busy), .m_ack_err(m_ack_err),
    .m_data_rd(m_data_rd), .owner_id(owner_id), .bus_active(bus_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] req, ena;
    logic       busy, ack;
    logic [2:0] gnt;
    logic       m_ena;
    logic [6:0] addr;
    logic       rw;
    logic [7:0] dwr;
    logic [2:0] rbusy, rack;
    logic       act;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t vt[12];
  int   rr_order[4];

  initial begin
    //         req     ena     bsy   ack   gnt     mena  addr   rw    dwr    rbusy   rack    act
    vt[0]  = '{3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 7'h00, 1'b0, 8'h00, 3'b111, 3'b000, 1'b0};
    vt[1]  = '{3'b001, 3'b001, 1'b0, 1'b0, 3'b001, 1'b1, 7'h60, 1'b0, 8'hC0, 3'b110, 3'b000, 1'b1};
    vt[2]  = '{3'b001, 3'b000, 1'b1, 1'b1, 3'b001, 1'b0, 7'h60, 1'b0, 8'hC0, 3'b111, 3'b001, 1'b1};
    vt[3]  = '{3'b000, 3'b000, 1'b1, 1'b0, 3'b001, 1'b0, 7'h60, 1'b0, 8'hC0, 3'b111, 3'b000, 1'b1};
    vt[4]  = '{3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 7'h00, 1'b0, 8'h00, 3'b111, 3'b000, 1'b0};
    vt[5]  = '{3'b111, 3'b111, 1'b0, 1'b0, 3'b010, 1'b1, 7'h61, 1'b1, 8'hC1, 3'b101, 3'b000, 1'b1};
    vt[6]  = '{3'b111, 3'b101, 1'b0, 1'b1, 3'b010, 1'b0, 7'h61, 1'b1, 8'hC1, 3'b101, 3'b010, 1'b1};
    vt[7]  = '{3'b101, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 7'h00, 1'b0, 8'h00, 3'b111, 3'b000, 1'b0};
    vt[8]  = '{3'b101, 3'b000, 1'b0, 1'b0, 3'b100, 1'b0, 7'h62, 1'b0, 8'hC2, 3'b011, 3'b000, 1'b1};
    vt[9]  = '{3'b001, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 7'h00, 1'b0, 8'h00, 3'b111, 3'b000, 1'b0};
    vt[10] = '{3'b001, 3'b001, 1'b0, 1'b0, 3'b001, 1'b1, 7'h60, 1'b0, 8'hC0, 3'b110, 3'b000, 1'b1};
    vt[11] = '{3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 7'h00, 1'b0, 8'h00, 3'b111, 3'b000, 1'b0};
    rr_order = '{0, 1, 2, 0};

    #1;
    chk("reset_gnt", {gnt, req_timeout, bus_active, m_ena}, {3'b000, 3'b000, 1'b0, 1'b0});
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    chk("data_rd_bcast", req_data_rd, 8'hA5);

    for (int i = 0; i < 12; i++) begin
      req = vt[i].req; req_ena = vt[i].ena; m_busy = vt[i].busy; m_ack_err = vt[i].ack;
      step();
      chk($sformatf("vec%0d", i),
          {gnt, m_ena, m_addr, m_rw, m_data_wr, req_busy, req_ack_err, bus_active},
          {vt[i].gnt, vt[i].m_ena, vt[i].addr, vt[i].rw, vt[i].dwr, vt[i].rbusy, vt[i].rack, vt[i].act});
    end

    // Owner drops req while the master is still busy: grant holds until busy falls.
    req = 3'b010; req_ena = 3'b000; m_busy = 1'b0; m_ack_err = 1'b0;
    step();
    chk("busy_hold_grant", gnt, 3'b010);
    req = 3'b000; m_busy = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      chk($sformatf("busy_hold_c%0d", i), gnt, 3'b010);
    end
    m_busy = 1'b0;
    step();
    chk("busy_hold_release", gnt, 3'b000);

    // Async reset while requester 2 owns the bus.
    req = 3'b100; req_ena = 3'b100;
    step();
    chk("prereset", {gnt, m_ena, bus_active, owner_id}, {3'b100, 1'b1, 1'b1, 2'd2});
    #2 rst_n = 1'b0;
    #1 chk("async_reset", {gnt, m_ena, bus_active}, {3'b000, 1'b0, 1'b0});
    req = 3'b111; req_ena = 3'b000;
    @(negedge clk) rst_n = 1'b1;

    // Round robin after reset, one idle cycle between owners.
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("rr_grant%0d", k), {gnt, owner_id}, {3'b001 << rr_order[k], 2'(rr_order[k])});
      repeat (19) @(posedge clk);
      #1 req = 3'b111 & ~(3'b001 << rr_order[k]);
      step();
      chk($sformatf("rr_gap%0d", k), gnt, 3'b000);
      req = (k < 3) ? 3'b111 : 3'b000;
    end

    // Watchdog: requester 2 hangs; pulse at grant+100, FORCE until busy drops.
    req = 3'b100; req_ena = 3'b100;
    step();
    chk("to_grant", gnt, 3'b100);
    m_busy = 1'b1;
    for (int i = 1; i < 100; i++) begin
      step();
      if (gnt !== 3'b100 || req_timeout !== 3'b000)
        chk($sformatf("to_hold_c%0d", i), {gnt, req_timeout}, {3'b100, 3'b000});
    end
    nvec++;
    step();
    chk("to_pulse", {req_timeout, gnt, m_ena, bus_active}, {3'b100, 3'b000, 1'b0, 1'b1});
    step();
    chk("to_force_wait", {req_timeout, m_ena, bus_active, m_addr}, {3'b000, 1'b0, 1'b1, 7'h00});
    m_busy = 1'b0;
    step();
    chk("to_idle", {bus_active, gnt}, {1'b0, 3'b000});
    repeat (3) step();
    chk("to_lockout", gnt, 3'b000);
    req = 3'b000;
    step();
    req = 3'b100;
    step();
    chk("to_regrant", gnt, 3'b100);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached, expected completion");
    $fatal(1);
  end

endmodule
